// File: rtl/agc_servo_pkg.sv
// Shared widths, state encoding and saturating helpers for the AGC servo loop.
package agc_servo_pkg;

    localparam int unsigned SCALE_W  = 17;
    localparam int unsigned OFFSET_W = 16;
    localparam int unsigned SQ_W     = 25;
    localparam int unsigned CNT_W    = 21;
    localparam int unsigned ERR_W    = SQ_W + 1;
    localparam int unsigned DIFF_W   = CNT_W + 1;
    localparam int unsigned DELTA_W  = DIFF_W + 1;
    localparam int unsigned ITER_W   = 16;
    localparam int unsigned USUM_W   = ERR_W + 2;
    localparam int unsigned SSUM_W   = DELTA_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_APPLY,
        ST_TICK,
        ST_RUN,
        ST_SETTLE,
        ST_CAPTURE,
        ST_CALC
    } state_e;

    // Unsigned base plus signed delta, clamped to [0, 2^SCALE_W-1].
    function automatic logic [SCALE_W-1:0] sat_add_unsigned(
        input logic        [SCALE_W-1:0] base,
        input logic signed [ERR_W-1:0]   delta
    );
        logic signed [USUM_W-1:0] sum;
        sum = USUM_W'($signed({1'b0, base})) + USUM_W'(delta);
        if (sum[USUM_W-1]) begin
            return '0;
        end else if (|sum[USUM_W-2:SCALE_W]) begin
            return '1;
        end else begin
            return sum[SCALE_W-1:0];
        end
    endfunction

    // Signed base plus signed delta, clamped to the OFFSET_W two's complement range.
    function automatic logic [OFFSET_W-1:0] sat_add_signed(
        input logic signed [OFFSET_W-1:0] base,
        input logic signed [DELTA_W-1:0]  delta
    );
        logic signed [SSUM_W-1:0]   sum;
        logic [SSUM_W-OFFSET_W:0]   hi;
        sum = SSUM_W'(base) + SSUM_W'(delta);
        hi  = sum[SSUM_W-1:OFFSET_W-1];
        if (sum[SSUM_W-1] && !(&hi)) begin
            return {1'b1, {(OFFSET_W-1){1'b0}}};
        end else if (!sum[SSUM_W-1] && (|hi)) begin
            return {1'b0, {(OFFSET_W-1){1'b1}}};
        end else begin
            return sum[OFFSET_W-1:0];
        end
    endfunction

endpackage

// File: rtl/agc_servo_update.sv
// Per-iteration scale/offset update, lock tracking and optional statistics.
// Optional statistics (iteration count, last error) built when AGC_SERVO_STATS_EN is defined.
module agc_servo_update
    import agc_servo_pkg::*;
#(
    parameter int unsigned SCALE_SHIFT  = 8,
    parameter int unsigned OFFSET_SHIFT = 4,
    parameter int unsigned SQ_TOL       = 1024,
    parameter int unsigned BAL_TOL      = 16,
    parameter int unsigned LOCK_COUNT   = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                init_i,
    input  logic                calc_i,
    input  logic                lock_clr_i,
    input  logic [SCALE_W-1:0]  scale_init_i,
    input  logic [OFFSET_W-1:0] offset_init_i,
    input  logic [SQ_W-1:0]     sq_target_i,
    input  logic [SQ_W-1:0]     sq_cap_i,
    input  logic [CNT_W-1:0]    gt_cap_i,
    input  logic [CNT_W-1:0]    lt_cap_i,
    output logic [SCALE_W-1:0]  scale_o,
    output logic [OFFSET_W-1:0] offset_o,
    output logic                locked_o,
    output logic [ITER_W-1:0]   iter_o,
    output logic [ERR_W-1:0]    sq_err_o
);

    localparam int unsigned LCNT_W = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam logic [LCNT_W-1:0] LOCK_LIM = LCNT_W'(LOCK_COUNT);

    logic signed [ERR_W-1:0]   err_c;
    logic signed [ERR_W-1:0]   scale_step_c;
    logic signed [DIFF_W-1:0]  diff_c;
    logic signed [DIFF_W-1:0]  off_step_c;
    logic signed [DELTA_W-1:0] off_delta_c;
    logic [ERR_W-1:0]          err_abs_c;
    logic [DIFF_W-1:0]         diff_abs_c;
    logic                      in_tol_c;

    logic [SCALE_W-1:0]  scale_q,  scale_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;
    logic [LCNT_W-1:0]   run_q,    run_d;
    logic                locked_q, locked_d;

    // Loop errors, steps and tolerance test from the captured accumulators.
    always_comb begin
        err_c        = $signed({1'b0, sq_target_i}) - $signed({1'b0, sq_cap_i});
        diff_c       = $signed({1'b0, gt_cap_i}) - $signed({1'b0, lt_cap_i});
        scale_step_c = err_c >>> SCALE_SHIFT;
        off_step_c   = diff_c >>> OFFSET_SHIFT;
        off_delta_c  = -(DELTA_W'(off_step_c));
        err_abs_c    = err_c[ERR_W-1] ? ERR_W'(-err_c) : ERR_W'(err_c);
        diff_abs_c   = diff_c[DIFF_W-1] ? DIFF_W'(-diff_c) : DIFF_W'(diff_c);
        in_tol_c     = (err_abs_c <= ERR_W'(SQ_TOL)) && (diff_abs_c <= DIFF_W'(BAL_TOL));
    end

    // Control values and lock run counter; lock follows the saturating counter.
    always_comb begin
        scale_d  = scale_q;
        offset_d = offset_q;
        run_d    = run_q;
        if (init_i) begin
            scale_d  = scale_init_i;
            offset_d = offset_init_i;
        end else if (calc_i) begin
            scale_d  = sat_add_unsigned(scale_q, scale_step_c);
            offset_d = sat_add_signed($signed(offset_q), off_delta_c);
        end
        if (lock_clr_i) begin
            run_d = '0;
        end else if (calc_i) begin
            if (in_tol_c) begin
                run_d = (run_q >= LOCK_LIM) ? run_q : run_q + LCNT_W'(1);
            end else begin
                run_d = '0;
            end
        end
        locked_d = (run_d >= LOCK_LIM);
    end

    // Update state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scale_q  <= '0;
            offset_q <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            scale_q  <= scale_d;
            offset_q <= offset_d;
            run_q    <= run_d;
            locked_q <= locked_d;
        end
    end

    assign scale_o  = scale_q;
    assign offset_o = offset_q;
    assign locked_o = locked_q;

`ifdef AGC_SERVO_STATS_EN
    logic [ITER_W-1:0] iter_q,   iter_d;
    logic [ERR_W-1:0]  sq_err_q, sq_err_d;

    // Iteration counter (wrapping) and last square error, updated per calculation.
    always_comb begin
        iter_d   = iter_q;
        sq_err_d = sq_err_q;
        if (calc_i) begin
            iter_d   = iter_q + ITER_W'(1);
            sq_err_d = err_c;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            iter_q   <= '0;
            sq_err_q <= '0;
        end else begin
            iter_q   <= iter_d;
            sq_err_q <= sq_err_d;
        end
    end

    assign iter_o   = iter_q;
    assign sq_err_o = sq_err_q;
`else
    assign iter_o   = '0;
    assign sq_err_o = '0;
`endif

endmodule

// File: rtl/dsp_counter_terminal_count.sv
// Fixed-length up counter with terminal-count flag; optionally halts at the last count.
module dsp_counter_terminal_count #(
    parameter int unsigned FIXED_TCOUNT   = 16,
    parameter bit          HALT_AT_TCOUNT = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c
);

    localparam int unsigned CW = (FIXED_TCOUNT > 1) ? $clog2(FIXED_TCOUNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(FIXED_TCOUNT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, then advance or wrap/hold at the terminal value.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            if (count_q == LAST) begin
                count_d = HALT_AT_TCOUNT ? count_q : '0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_c = (count_q == LAST);

endmodule

// File: rtl/agc_servo.sv
// Closed-loop AGC servo: window/settle/capture/calc/load/apply sequencing for one agc_core.
// Optional statistics ports (iter_o, sq_err_o) are live only when AGC_SERVO_STATS_EN is defined.
module agc_servo
    import agc_servo_pkg::*;
#(
    parameter int unsigned TCOUNT       = 131072,
    parameter int unsigned SETTLE       = 6,
    parameter int unsigned SCALE_SHIFT  = 8,
    parameter int unsigned OFFSET_SHIFT = 4,
    parameter int unsigned SQ_TOL       = 1024,
    parameter int unsigned BAL_TOL      = 16,
    parameter int unsigned LOCK_COUNT   = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [SQ_W-1:0]     sq_target_i,
    input  logic [SCALE_W-1:0]  scale_init_i,
    input  logic [OFFSET_W-1:0] offset_init_i,
    input  logic [SQ_W-1:0]     sq_accum_i,
    input  logic [CNT_W-1:0]    gt_accum_i,
    input  logic [CNT_W-1:0]    lt_accum_i,
    output logic                agc_tick_o,
    output logic                agc_ce_o,
    output logic [SCALE_W-1:0]  agc_scale_o,
    output logic [OFFSET_W-1:0] agc_offset_o,
    output logic                agc_scale_ce_o,
    output logic                agc_offset_ce_o,
    output logic                agc_apply_o,
    output logic                busy_o,
    output logic                locked_o,
    output logic [ITER_W-1:0]   iter_o,
    output logic [ERR_W-1:0]    sq_err_o
);

    state_e state_q, state_d;

    logic tick_q, tick_d;
    logic ce_q, ce_d;
    logic load_q, load_d;
    logic apply_q, apply_d;
    logic busy_q, busy_d;

    logic [SQ_W-1:0]  sq_cap_q, sq_cap_d;
    logic [CNT_W-1:0] gt_cap_q, gt_cap_d;
    logic [CNT_W-1:0] lt_cap_q, lt_cap_d;

    logic load_init_c;
    logic lock_clr_c;
    logic win_tc_c;
    logic settle_tc_c;

    // Measurement window: cleared on the tick, counts through RUN.
    dsp_counter_terminal_count #(
        .FIXED_TCOUNT   (TCOUNT),
        .HALT_AT_TCOUNT (1'b1)
    ) u_win_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q == ST_TICK),
        .en_i  (state_q == ST_RUN),
        .tc_c  (win_tc_c)
    );

    // Settle delay: cleared during RUN, counts through SETTLE.
    dsp_counter_terminal_count #(
        .FIXED_TCOUNT   (SETTLE),
        .HALT_AT_TCOUNT (1'b1)
    ) u_settle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q == ST_RUN),
        .en_i  (state_q == ST_SETTLE),
        .tc_c  (settle_tc_c)
    );

    // Next state, update controls, accumulator capture and next registered outputs.
    always_comb begin
        state_d     = state_q;
        load_init_c = 1'b0;
        lock_clr_c  = 1'b0;
        sq_cap_d    = sq_cap_q;
        gt_cap_d    = gt_cap_q;
        lt_cap_d    = lt_cap_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d     = ST_LOAD;
                    load_init_c = 1'b1;
                end
            end
            ST_LOAD:  state_d = ST_APPLY;
            ST_APPLY: begin
                if (enable_i) begin
                    state_d = ST_TICK;
                end else begin
                    state_d    = ST_IDLE;
                    lock_clr_c = 1'b1;
                end
            end
            ST_TICK:  state_d = ST_RUN;
            ST_RUN: begin
                if (win_tc_c) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_tc_c) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                sq_cap_d = sq_accum_i;
                gt_cap_d = gt_accum_i;
                lt_cap_d = lt_accum_i;
                state_d  = ST_CALC;
            end
            ST_CALC:  state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
        tick_d  = (state_d == ST_TICK);
        ce_d    = (state_d == ST_RUN);
        load_d  = (state_d == ST_LOAD);
        apply_d = (state_d == ST_APPLY);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, strobe and capture registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            tick_q   <= 1'b0;
            ce_q     <= 1'b0;
            load_q   <= 1'b0;
            apply_q  <= 1'b0;
            busy_q   <= 1'b0;
            sq_cap_q <= '0;
            gt_cap_q <= '0;
            lt_cap_q <= '0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            ce_q     <= ce_d;
            load_q   <= load_d;
            apply_q  <= apply_d;
            busy_q   <= busy_d;
            sq_cap_q <= sq_cap_d;
            gt_cap_q <= gt_cap_d;
            lt_cap_q <= lt_cap_d;
        end
    end

    agc_servo_update #(
        .SCALE_SHIFT  (SCALE_SHIFT),
        .OFFSET_SHIFT (OFFSET_SHIFT),
        .SQ_TOL       (SQ_TOL),
        .BAL_TOL      (BAL_TOL),
        .LOCK_COUNT   (LOCK_COUNT)
    ) u_update (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .init_i        (load_init_c),
        .calc_i        (state_q == ST_CALC),
        .lock_clr_i    (lock_clr_c),
        .scale_init_i  (scale_init_i),
        .offset_init_i (offset_init_i),
        .sq_target_i   (sq_target_i),
        .sq_cap_i      (sq_cap_q),
        .gt_cap_i      (gt_cap_q),
        .lt_cap_i      (lt_cap_q),
        .scale_o       (agc_scale_o),
        .offset_o      (agc_offset_o),
        .locked_o      (locked_o),
        .iter_o        (iter_o),
        .sq_err_o      (sq_err_o)
    );

    // The window enable is masked by reset so the core stops accumulating in the reset cycle itself.
    assign agc_ce_o        = ce_q & ~rst_i;
    assign agc_tick_o      = tick_q;
    assign agc_scale_ce_o  = load_q;
    assign agc_offset_ce_o = load_q;
    assign agc_apply_o     = apply_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_agc_servo.sv
// Directed scoreboard bench for agc_servo (TCOUNT=16, SETTLE=6).
module tb_agc_servo;

    logic        clk;
    logic        rst_i;
    logic        enable_i;
    logic [24:0] sq_target_i;
    logic [16:0] scale_init_i;
    logic [15:0] offset_init_i;
    logic [24:0] sq_accum_i;
    logic [20:0] gt_accum_i;
    logic [20:0] lt_accum_i;
    logic        agc_tick_o;
    logic        agc_ce_o;
    logic [16:0] agc_scale_o;
    logic [15:0] agc_offset_o;
    logic        agc_scale_ce_o;
    logic        agc_offset_ce_o;
    logic        agc_apply_o;
    logic        busy_o;
    logic        locked_o;
    logic [15:0] iter_o;
    logic [25:0] sq_err_o;

    agc_servo #(
        .TCOUNT (16),
        .SETTLE (6)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .sq_target_i     (sq_target_i),
        .scale_init_i    (scale_init_i),
        .offset_init_i   (offset_init_i),
        .sq_accum_i      (sq_accum_i),
        .gt_accum_i      (gt_accum_i),
        .lt_accum_i      (lt_accum_i),
        .agc_tick_o      (agc_tick_o),
        .agc_ce_o        (agc_ce_o),
        .agc_scale_o     (agc_scale_o),
        .agc_offset_o    (agc_offset_o),
        .agc_scale_ce_o  (agc_scale_ce_o),
        .agc_offset_ce_o (agc_offset_ce_o),
        .agc_apply_o     (agc_apply_o),
        .busy_o          (busy_o),
        .locked_o        (locked_o),
        .iter_o          (iter_o),
        .sq_err_o        (sq_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0] scale;
        logic [15:0] offset;
        logic        locked;
        logic [15:0] iter;
        logic [25:0] err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model of the loop state.
    int m_scale  = 0;
    int m_offset = 0;
    int m_run    = 0;
    int m_iter   = 0;
    int m_err    = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.scale  = 17'(m_scale);
        e.offset = 16'(m_offset);
        e.locked = (m_run >= 3);
`ifdef AGC_SERVO_STATS_EN
        e.iter   = 16'(m_iter);
        e.err    = 26'(m_err);
`else
        e.iter   = '0;
        e.err    = '0;
`endif
        sb_q.push_back(e);
    endtask

    // Request a run from IDLE with the given initial controls.
    task automatic start(input logic [16:0] s, input logic [15:0] o);
        scale_init_i  = s;
        offset_init_i = o;
        m_scale  = int'(s);
        m_offset = int'($signed(o));
        m_run    = 0;
        push_exp();
        enable_i = 1'b1;
    endtask

    // Present accumulators for the next capture and predict the resulting load.
    task automatic drive_iter(input int target, input int accum, input int g, input int l);
        int err;
        int diff;
        sq_target_i = 25'(target);
        sq_accum_i  = 25'(accum);
        gt_accum_i  = 21'(g);
        lt_accum_i  = 21'(l);
        err  = target - accum;
        diff = g - l;
        m_scale  = clamp(m_scale + (err >>> 8), 0, 131071);
        m_offset = clamp(m_offset - (diff >>> 4), -32768, 32767);
        if (iabs(err) <= 1024 && iabs(diff) <= 16) m_run = (m_run < 3) ? m_run + 1 : 3;
        else m_run = 0;
        m_iter++;
        m_err = err;
        push_exp();
    endtask

    // Wait for the next load strobe, compare against the scoreboard, then step into APPLY.
    task automatic wait_load(input string tag);
        exp_t e;
        for (int i = 0; i < 200 && !agc_scale_ce_o; i++) step();
        if (!agc_scale_ce_o) begin
            chk({tag, "_timeout"}, 32'(agc_scale_ce_o), 32'd1);
        end else if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, sb_q.size(), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_offset_ce"}, 32'(agc_offset_ce_o), 32'd1);
            chk({tag, "_scale"},     32'(agc_scale_o),     32'(e.scale));
            chk({tag, "_offset"},    32'(agc_offset_o),    32'(e.offset));
            chk({tag, "_locked"},    32'(locked_o),        32'(e.locked));
            chk({tag, "_iter"},      32'(iter_o),          32'(e.iter));
            chk({tag, "_sq_err"},    32'(sq_err_o),        32'(e.err));
        end
        step();
    endtask

    task automatic wait_ce(input string tag);
        for (int i = 0; i < 50 && !agc_ce_o; i++) step();
        chk({tag, "_ce_seen"}, 32'(agc_ce_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i         = 1'b1;
        enable_i      = 1'b0;
        sq_target_i   = '0;
        scale_init_i  = '0;
        offset_init_i = '0;
        sq_accum_i    = '0;
        gt_accum_i    = '0;
        lt_accum_i    = '0;
        repeat (3) step();

        // Reset state.
        chk("rst_busy",     32'(busy_o),         32'd0);
        chk("rst_ce",       32'(agc_ce_o),       32'd0);
        chk("rst_tick",     32'(agc_tick_o),     32'd0);
        chk("rst_scale_ce", 32'(agc_scale_ce_o), 32'd0);
        chk("rst_apply",    32'(agc_apply_o),    32'd0);
        chk("rst_scale",    32'(agc_scale_o),    32'd0);
        chk("rst_offset",   32'(agc_offset_o),   32'd0);
        chk("rst_locked",   32'(locked_o),       32'd0);
        chk("rst_iter",     32'(iter_o),         32'd0);
        chk("rst_sq_err",   32'(sq_err_o),       32'd0);
        rst_i = 1'b0;
        step();
        chk("idle_busy", 32'(busy_o), 32'd0);

        // First iteration: load, apply, tick, 16-cycle window.
        start(17'h04000, 16'h0000);
        drive_iter(32'h100000, 32'h100400, 1000, 200);
        wait_load("load0");
        chk("seq_apply",    32'(agc_apply_o),    32'd1);
        chk("seq_scale_ce", 32'(agc_scale_ce_o), 32'd0);
        step();
        chk("seq_tick",  32'(agc_tick_o),  32'd1);
        chk("seq_apply0", 32'(agc_apply_o), 32'd0);
        chk("seq_ce0",   32'(agc_ce_o),    32'd0);
        step();
        n = 0;
        while (agc_ce_o && n < 40) begin
            n++;
            step();
        end
        chk("run_len", 32'(n), 32'd16);
        chk("settle_busy", 32'(busy_o), 32'd1);
        wait_load("iter1");

        // Three in-tolerance iterations build lock, one out-of-tolerance drops it.
        for (int k = 0; k < 3; k++) begin
            drive_iter(32'h100000, 32'h100000, 100, 100);
            wait_load($sformatf("lock%0d", k));
        end
        drive_iter(32'h100000, 32'h0FF800, 100, 100);
        wait_load("unlock");

        // Enable dropped mid-window: iteration completes through APPLY then IDLE.
        drive_iter(32'h100000, 32'h0FF800, 100, 100);
        wait_ce("drain");
        enable_i = 1'b0;
        wait_load("drain");
        chk("drain_apply", 32'(agc_apply_o), 32'd1);
        step();
        m_run = 0;
        chk("drain_busy",   32'(busy_o),     32'd0);
        chk("drain_ce",     32'(agc_ce_o),   32'd0);
        chk("drain_locked", 32'(locked_o),   32'd0);
        step();
        chk("drain_tick",   32'(agc_tick_o), 32'd0);

        // Saturation of both controls.
        start(17'h1FFF0, 16'h8010);
        drive_iter(32'h010000, 0, 32'h1000, 0);
        wait_load("sat_init");
        wait_load("sat");

        // Reset in RUN cycle 5.
        wait_ce("rst");
        repeat (4) step();
        chk("run5_ce", 32'(agc_ce_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rst_ce_drop", 32'(agc_ce_o), 32'd0);
        step();
        chk("mid_rst_ce",     32'(agc_ce_o),       32'd0);
        chk("mid_rst_busy",   32'(busy_o),         32'd0);
        chk("mid_rst_scale",  32'(agc_scale_o),    32'd0);
        chk("mid_rst_offset", 32'(agc_offset_o),   32'd0);
        chk("mid_rst_strobe", 32'({agc_tick_o, agc_scale_ce_o, agc_offset_ce_o, agc_apply_o}), 32'd0);
        chk("mid_rst_locked", 32'(locked_o),       32'd0);
        chk("mid_rst_iter",   32'(iter_o),         32'd0);
        chk("mid_rst_sq_err", 32'(sq_err_o),       32'd0);
        rst_i    = 1'b0;
        enable_i = 1'b0;
        repeat (3) step();
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
